// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: redirect input, instruction-memory request/response,
// decoded-instruction output handshake and the sticky response-error flag.
interface instr_fetch_queue_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        resp_err;

    modport master (
        input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid,
               mem_resp_data, out_ready,
        output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc, resp_err
    );

    modport slave (
        output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid,
               mem_resp_data, out_ready,
        input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc, resp_err
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch into a circular buffer,
// with redirect flush and dropping of responses to requests issued before a redirect.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 reset,
    instr_fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          resp_err_q, resp_err_d;

    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] pc_mem_q [DEPTH];

    logic [31:0] redirect_pc_aligned;
    logic        credit_ok;
    logic        req_valid;
    logic        req_fire;
    logic        resp_acc;
    logic        resp_spur;
    logic        out_valid;
    logic        pop;
    logic        push;

    assign redirect_pc_aligned = bus.redirect_pc & 32'hFFFF_FFFC;

    // Handshake qualifiers; redirect and reset suppress both request and output.
    always_comb begin
        credit_ok = ({1'b0, occ_q} + {1'b0, outst_q}) < DEPTH_L;
        req_valid = !reset && !bus.redirect_valid && credit_ok;
        req_fire  = req_valid && bus.mem_req_ready;
        resp_acc  = bus.mem_resp_valid && (outst_q != '0);
        resp_spur = bus.mem_resp_valid && (outst_q == '0);
        out_valid = !reset && !bus.redirect_valid && (occ_q != '0);
        pop       = out_valid && bus.out_ready;
        push      = !reset && resp_acc && !bus.redirect_valid && (drop_q == '0);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        occ_d      = occ_q;
        drop_d     = drop_q;
        head_d     = head_q;
        tail_d     = tail_q;
        resp_err_d = resp_err_q | resp_spur;
        outst_d    = outst_q + CW'(req_fire) - CW'(resp_acc);

        if (bus.redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            occ_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = redirect_pc_aligned;
            resp_pc_d  = redirect_pc_aligned;
            drop_d     = outst_q - CW'(resp_acc);
        end else begin
            if (resp_acc && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                tail_d    = tail_q + PW'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            occ_d = occ_q + CW'(push) - CW'(pop);
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            occ_q      <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            occ_q      <= occ_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            resp_err_q <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[tail_q] <= bus.mem_resp_data;
            pc_mem_q[tail_q]    <= resp_pc_q;
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = reset ? RESET_PC : fetch_pc_q;
    assign bus.out_valid     = out_valid;
    assign bus.out_instr     = reset ? '0 : instr_mem_q[head_q];
    assign bus.out_pc        = reset ? '0 : pc_mem_q[head_q];
    assign bus.resp_err      = resp_err_q;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus randomized traffic against
// a queue-based behavioural model of the fetch pipeline.
module tb_instr_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    instr_fetch_queue_if bus();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } infl_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    infl_t       infl[$];
    ent_t        m_q[$];
    logic [31:0] m_pc = RESET_PC;
    bit          m_err = 1'b0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned resp_prob = 100;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic bit m_req_valid();
        return !reset && !bus.redirect_valid && ((m_q.size() + infl.size()) < DEPTH);
    endfunction

    function automatic bit m_out_valid();
        return !reset && !bus.redirect_valid && (m_q.size() > 0);
    endfunction

    // Reference model: in-flight requests carry their own address and a stale mark.
    always @(posedge clk) begin : model
        infl_t e;
        infl_t r;
        ent_t  n;
        bit    rv, ov, kept;
        cyc++;
        if (reset) begin
            m_pc = RESET_PC;
            m_q.delete();
            infl.delete();
            m_err = 1'b0;
        end else begin
            rv   = m_req_valid();
            ov   = m_out_valid();
            kept = 1'b0;
            if (bus.mem_resp_valid) begin
                if (infl.size() == 0) m_err = 1'b1;
                else begin
                    e    = infl.pop_front();
                    kept = !e.stale;
                end
            end
            if (bus.redirect_valid) begin
                m_q.delete();
                foreach (infl[i]) infl[i].stale = 1'b1;
                m_pc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (ov && bus.out_ready) void'(m_q.pop_front());
                if (kept) begin
                    n.pc    = e.addr;
                    n.instr = bus.mem_resp_data;
                    m_q.push_back(n);
                end
                if (rv && bus.mem_req_ready) begin
                    r.addr  = m_pc;
                    r.due   = cyc + lat - 1;
                    r.stale = 1'b0;
                    infl.push_back(r);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit rv, ov;
        if (reset) begin
            check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_req_addr", bus.mem_req_addr, RESET_PC);
            check("rst_out_instr", bus.out_instr, 32'd0);
            check("rst_out_pc", bus.out_pc, 32'd0);
        end else begin
            rv = m_req_valid();
            ov = m_out_valid();
            check("req_valid", 32'(bus.mem_req_valid), 32'(rv));
            if (rv) check("req_addr", bus.mem_req_addr, m_pc);
            check("out_valid", 32'(bus.out_valid), 32'(ov));
            if (ov) begin
                check("out_pc", bus.out_pc, m_q[0].pc);
                check("out_instr", bus.out_instr, m_q[0].instr);
            end
            check("resp_err", 32'(bus.resp_err), 32'(m_err));
        end
    end

    task automatic drive(input bit rst, input bit redir, input logic [31:0] rpc,
                         input bit rdy, input bit ordy, input bit spur);
        @(posedge clk);
        #1;
        reset              = rst;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.mem_req_ready  = rdy;
        bus.out_ready      = ordy;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = $urandom;
        if (spur) bus.mem_resp_valid = 1'b1;
        else if (!rst && infl.size() > 0) begin
            if (infl[0].due <= cyc && $urandom_range(99) < resp_prob) begin
                bus.mem_resp_valid = 1'b1;
                bus.mem_resp_data  = instr_of(infl[0].addr);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int unsigned nreq;
        int unsigned k;
        bit          got;
        bit          prev_redir;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.out_ready      = 1'b0;

        // Reset values and streaming at latency 1
        do_reset();
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_req_addr", bus.mem_req_addr, 32'h0);
        lat = 1;
        for (int unsigned w = 0; w < 10; w++) begin
            drive(0, 0, 0, 1, 1, 0);
            if (w == 0) begin
                check("first_req_valid", 32'(bus.mem_req_valid), 32'd1);
                check("first_req_addr", bus.mem_req_addr, 32'h0);
            end
            if (w >= 2) begin
                check("stream_valid", 32'(bus.out_valid), 32'd1);
                check("stream_pc", bus.out_pc, 32'((w - 2) * 4));
                check("stream_instr", bus.out_instr, instr_of(32'((w - 2) * 4)));
            end
        end

        // Backpressure: exactly DEPTH requests, then resume at 0x10
        do_reset();
        nreq = 0;
        for (int unsigned w = 0; w < 10; w++) begin
            drive(0, 0, 0, 1, 0, 0);
            if (bus.mem_req_valid) nreq++;
        end
        check("bp_req_count", nreq, 32'd4);
        check("bp_req_valid", 32'(bus.mem_req_valid), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_out_pc", bus.out_pc, 32'h0);
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 1, 0);
        check("bp_resume_valid", 32'(bus.mem_req_valid), 32'd1);
        check("bp_resume_addr", bus.mem_req_addr, 32'h10);

        // Redirect with three requests in flight at latency 4
        do_reset();
        lat = 4;
        repeat (3) drive(0, 0, 0, 1, 1, 0);
        drive(0, 1, 32'h103, 1, 1, 0);
        check("redir_no_req", 32'(bus.mem_req_valid), 32'd0);
        drive(0, 0, 0, 1, 1, 0);
        check("redir_req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("redir_req_addr", bus.mem_req_addr, 32'h100);
        got = 0;
        k = 4;
        for (int unsigned w = 0; w < 20 && !got; w++) begin
            drive(0, 0, 0, 1, 1, 0);
            k++;
            got = bus.out_valid;
        end
        check("redir_first_window", k, 32'd9);
        check("redir_first_pc", got ? bus.out_pc : 32'hDEAD_BEEF, 32'h100);

        // Address wrap after redirect
        do_reset();
        lat = 1;
        drive(0, 1, 32'hFFFF_FFF8, 1, 1, 0);
        drive(0, 0, 0, 1, 1, 0);
        check("wrap_addr0", bus.mem_req_addr, 32'hFFFF_FFF8);
        drive(0, 0, 0, 1, 1, 0);
        check("wrap_addr1", bus.mem_req_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1, 1, 0);
        check("wrap_addr2", bus.mem_req_addr, 32'h0000_0000);
        check("wrap_valid2", 32'(bus.mem_req_valid), 32'd1);

        // Pop, filling response and redirect in the same cycle
        do_reset();
        lat = 6;
        repeat (9) drive(0, 0, 0, 1, 0, 0);
        check("sim_pre_valid", 32'(bus.out_valid), 32'd1);
        check("sim_pre_pc", bus.out_pc, 32'h0);
        drive(0, 1, 32'h200, 1, 1, 0);
        check("sim_out_blocked", 32'(bus.out_valid), 32'd0);
        drive(0, 0, 0, 1, 1, 0);
        check("sim_flushed", 32'(bus.out_valid), 32'd0);
        check("sim_no_err", 32'(bus.resp_err), 32'd0);
        got = 0;
        for (int unsigned w = 0; w < 30 && !got; w++) begin
            drive(0, 0, 0, 1, 1, 0);
            got = bus.out_valid;
        end
        check("sim_first_pc", got ? bus.out_pc : 32'hDEAD_BEEF, 32'h200);

        // Reset forgets in-flight requests; a later response is spurious
        do_reset();
        lat = 5;
        repeat (2) drive(0, 0, 0, 1, 1, 0);
        do_reset();
        drive(0, 0, 0, 0, 1, 1);
        check("spur_before", 32'(bus.resp_err), 32'd0);
        drive(0, 0, 0, 0, 1, 0);
        check("spur_set", 32'(bus.resp_err), 32'd1);
        repeat (5) drive(0, 0, 0, 1, 1, 0);
        check("spur_sticky", 32'(bus.resp_err), 32'd1);
        do_reset();
        drive(0, 0, 0, 1, 1, 0);
        check("spur_cleared", 32'(bus.resp_err), 32'd0);

        // Randomized traffic
        resp_prob  = 80;
        prev_redir = 0;
        for (int unsigned i = 0; i < 4000; i++) begin
            bit rst, redir, spur;
            lat   = $urandom_range(4, 1);
            rst   = ($urandom_range(599) == 0);
            redir = prev_redir ? ($urandom_range(99) < 30) : ($urandom_range(99) < 5);
            spur  = (infl.size() == 0) && ($urandom_range(299) == 0);
            drive(rst, redir, $urandom, ($urandom_range(99) < 75), ($urandom_range(99) < 70), spur);
            prev_redir = redir;
        end
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
